// File: rtl/tqvp_hx2003_pulse_receiver_pkg.sv
// Constants shared by the pulse receiver and the transmitter driver.
// Register map, interrupt bits, state codes and symbol layout.
package tqvp_hx2003_pulse_receiver_pkg;

   localparam logic [5:0] REG0_ADDR    = 6'h00;
   localparam logic [5:0] REG1_ADDR    = 6'h04;
   localparam logic [5:0] STATUS_ADDR  = 6'h08;
   localparam logic [5:0] SYM_MEM_BASE = 6'h20;

   localparam int INT_FRAME_DONE = 0;
   localparam int INT_OVERFLOW   = 1;
   localparam int INT_SYMBOL_RX  = 2;

   localparam int SYM_LEVEL_BIT = 1;
   localparam int SYM_LONG_BIT  = 0;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_START = 2'd1,
      ST_MEASURE    = 2'd2,
      ST_DONE       = 2'd3
   } rx_state_e;

   // Low bit of a symbol's 2-bit slot within its memory word.
   function automatic logic [4:0] sym_lsb(input logic [3:0] slot);
      return {slot, 1'b0};
   endfunction

endpackage

// File: rtl/pulse_receiver_tick_prescaler.sv
// Tick generator: one-cycle tick every 2^prescaler clocks.
// Clear restarts the phase so the first tick lands on the next clock.
module pulse_receiver_tick_prescaler (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic [3:0] prescaler,
   output logic       tick
);

   logic [14:0] cnt;
   logic [14:0] mask;

   assign mask = ~(15'h7fff << prescaler);
   assign tick = !clear && ((cnt & mask) == 15'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 15'd1;
      end
   end

endmodule

// File: rtl/tqvp_hx2003_pulse_receiver.sv
// TinyQV pulse receiver: measures pulse widths on one input pin and
// packs {level, long} symbols in the transmitter's program-data format.
module tqvp_hx2003_pulse_receiver
   import tqvp_hx2003_pulse_receiver_pkg::*;
#(
   parameter int NUM_SYMBOL_WORDS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   localparam logic [7:0] LAST_SYM = 8'(NUM_SYMBOL_WORDS * 16 - 1);

   logic [3:0]  int_status;
   logic [3:0]  int_mask;
   logic        armed;
   logic        invert_input;
   logic        idle_level;
   logic [7:0]  thr_low;
   logic [7:0]  thr_high;
   logic [7:0]  idle_timeout;
   logic [3:0]  prescaler;
   logic [2:0]  pin_sel;

   rx_state_e   state;
   logic [7:0]  symbol_count;
   logic [7:0]  dur;
   logic        lvl_q;
   logic [31:0] mem [NUM_SYMBOL_WORDS];

   logic        lvl;
   logic        lvl_edge;
   logic        at_idle;
   logic        tick;
   logic        presc_clear;
   logic        reg0_wr;
   logic        reg0_wide;
   logic        reg1_wr;
   logic        arm_wr;
   logic        abort_wr;
   logic        rec;
   logic        full_hit;
   logic        timeout;
   logic        start;
   logic        frame_end;
   logic [1:0]  sym;
   logic [3:0]  events;
   logic [3:0]  w1c;
   logic        unused;

   assign lvl      = ui_in[pin_sel] ^ invert_input;
   assign lvl_edge = lvl != lvl_q;
   assign at_idle  = lvl_q == idle_level;

   assign reg0_wr   = data_write_n != 2'b11 && address == REG0_ADDR;
   assign reg0_wide = data_write_n != 2'b00;
   assign reg1_wr   = data_write_n == 2'b10 && address == REG1_ADDR;
   assign arm_wr    = reg0_wr && data_in[7] && !armed;
   assign abort_wr  = reg0_wr && !data_in[7];
   assign w1c       = reg0_wr ? {1'b0, data_in[2:0]} : 4'd0;

   assign rec      = state == ST_MEASURE && lvl_edge && !abort_wr;
   assign full_hit = symbol_count == LAST_SYM;
   assign start    = state == ST_WAIT_START && lvl_edge && at_idle
                     && !abort_wr;
   // An edge in the same cycle always beats the timeout.
   assign timeout  = state == ST_MEASURE && !lvl_edge && tick && at_idle
                     && idle_timeout != 8'd0 && dur == idle_timeout
                     && !abort_wr;
   assign frame_end   = timeout || (rec && full_hit);
   assign presc_clear = arm_wr || rec || start;

   always_comb begin
      sym = '0;
      sym[SYM_LEVEL_BIT] = lvl_q;
      sym[SYM_LONG_BIT]  = dur >= (lvl_q ? thr_high : thr_low);
   end

   always_comb begin
      events = '0;
      events[INT_FRAME_DONE] = frame_end;
      events[INT_OVERFLOW]   = rec && full_hit;
      events[INT_SYMBOL_RX]  = rec;
   end

   pulse_receiver_tick_prescaler u_prescaler (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (presc_clear),
      .prescaler (prescaler),
      .tick      (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         int_status   <= '0;
         int_mask     <= '0;
         armed        <= 1'b0;
         invert_input <= 1'b0;
         idle_level   <= 1'b0;
         thr_low      <= '0;
         thr_high     <= '0;
         idle_timeout <= '0;
         prescaler    <= '0;
         pin_sel      <= '0;
         lvl_q        <= 1'b0;
      end else begin
         lvl_q      <= lvl;
         int_status <= (int_status & ~w1c) | events;
         if (arm_wr) begin
            armed <= 1'b1;
         end else if (abort_wr || frame_end) begin
            armed <= 1'b0;
         end
         if (reg0_wr && reg0_wide) begin
            int_mask     <= data_in[11:8];
            invert_input <= data_in[12];
            idle_level   <= data_in[13];
         end
         if (reg1_wr) begin
            thr_low      <= data_in[7:0];
            thr_high     <= data_in[15:8];
            idle_timeout <= data_in[23:16];
            prescaler    <= data_in[27:24];
            pin_sel      <= data_in[30:28];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         symbol_count <= '0;
         dur          <= '0;
      end else if (abort_wr) begin
         state <= ST_IDLE;
      end else if (arm_wr) begin
         state        <= ST_WAIT_START;
         symbol_count <= '0;
         dur          <= '0;
      end else begin
         case (state)
            ST_WAIT_START: begin
               if (start) begin
                  state <= ST_MEASURE;
                  dur   <= '0;
               end
            end
            ST_MEASURE: begin
               if (rec) begin
                  symbol_count <= symbol_count + 8'd1;
                  dur          <= '0;
                  if (full_hit) state <= ST_DONE;
               end else if (timeout) begin
                  state <= ST_DONE;
               end else if (tick && dur != 8'hff) begin
                  dur <= dur + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Symbol memory is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (rec) begin
         mem[symbol_count[6:4]][sym_lsb(symbol_count[3:0]) +: 2] <= sym;
      end
   end

   always_comb begin
      data_out = '0;
      if (data_read_n != 2'b11) begin
         if (address[5] == SYM_MEM_BASE[5]) begin
            data_out = mem[address[4:2]];
         end else begin
            case (address[3:2])
               REG0_ADDR[3:2]:
                  data_out = {16'd0, 2'b00, idle_level, invert_input,
                              int_mask, armed, 3'd0, int_status};
               REG1_ADDR[3:2]:
                  data_out = {1'b0, pin_sel, prescaler, idle_timeout,
                              thr_high, thr_low};
               STATUS_ADDR[3:2]:
                  data_out = {14'd0, dur, state, symbol_count};
               default:
                  data_out = '0;
            endcase
         end
      end
   end

   assign uo_out = {5'd0, lvl_q,
                    state == ST_WAIT_START || state == ST_MEASURE, 1'b0};
   assign data_ready     = 1'b1;
   assign user_interrupt = |(int_status & int_mask);

   assign unused = ^{data_in[31], data_in[15:14], data_in[6:3],
                     address[1:0]};

endmodule
